// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage controller (master)
// and a multi-cycle data memory (slave).
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_busy;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_busy, mem_done, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_busy, mem_done, mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues multi-cycle data-memory accesses from EX/MEM, stalls the
// pipeline while one is outstanding and produces the MEM/WB register. Option: ALIGN_CHECK_EN.
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_stage_ctrl_if.master  mem,
    input  logic [DATA_W-1:0] aluResIn,
    input  logic [DATA_W-1:0] memWriteDataIn,
    input  logic [REG_W-1:0]  writeRegIn,
    input  logic              MemReadIn,
    input  logic              MemWriteIn,
    input  logic              MemToRegIn,
    input  logic              RegWriteIn,
    input  logic              writeRegValidIn,
    input  logic              halt_in,
    output logic              stallMem,
    output logic [DATA_W-1:0] aluResOut,
    output logic [DATA_W-1:0] memReadDataOut,
    output logic [REG_W-1:0]  writeRegOut,
    output logic              MemToRegOut,
    output logic              RegWriteOut,
    output logic              writeRegValidOut,
    output logic              halt_out,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       err_n;
    logic       acc;
    logic       load;

    assign acc = MemReadIn | MemWriteIn;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        err_n         = err;
        load          = 1'b0;
        stallMem      = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_addr  = aluResIn;
        mem.mem_wdata = memWriteDataIn;

        unique case (state)
            IDLE: begin
                if (!acc) begin
                    load = 1'b1;
                end else begin
`ifdef ALIGN_CHECK_EN
                    if (aluResIn[0]) begin
                        err_n   = 1'b1;
                        state_n = ERR;
                    end else
`endif
                    begin
                        mem.mem_req = 1'b1;
                        mem.mem_wr  = MemWriteIn;
                        if (mem.mem_done) begin
                            load = 1'b1;
                        end else if (mem.mem_busy) begin
                            stallMem = 1'b1;
                        end else begin
                            stallMem = 1'b1;
                            state_n  = WAIT;
                            cnt_n    = 8'd1;
                        end
                    end
                end
            end
            WAIT: begin
                stallMem = 1'b1;
                if (mem.mem_done) begin
                    stallMem = 1'b0;
                    load     = 1'b1;
                    state_n  = IDLE;
                end else if (cnt == TIMEOUT_C) begin
                    err_n   = 1'b1;
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ERR: begin
                // Dead until reset: bubbles only, but halt still flows so the core can stop.
            end
            default: state_n = IDLE;
        endcase

        // Outputs must read 0 for the whole reset pulse, not only after the next edge.
        if (!rst) begin
            stallMem    = 1'b0;
            mem.mem_req = 1'b0;
            mem.mem_wr  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            err              <= 1'b0;
            aluResOut        <= '0;
            memReadDataOut   <= '0;
            writeRegOut      <= '0;
            MemToRegOut      <= 1'b0;
            RegWriteOut      <= 1'b0;
            writeRegValidOut <= 1'b0;
            halt_out         <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            err            <= err_n;
            // Data fields load every cycle; a bubble is defined by its control bits alone.
            aluResOut      <= aluResIn;
            writeRegOut    <= writeRegIn;
            memReadDataOut <= (MemReadIn && !MemWriteIn) ? mem.mem_rdata : '0;
            MemToRegOut      <= load & MemToRegIn;
            RegWriteOut      <= load & RegWriteIn;
            writeRegValidOut <= load & writeRegValidIn;
            halt_out         <= (load || state == ERR) & halt_in;
        end
    end

endmodule
